// File: rtl/vertex_pkg.sv
// Shared pipeline-control types for the five-stage core: hazard FSM states,
// register-index constants and the packed control bundle used by hazard_ctrl.
package vertex_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic mem_wb_bubble;
    logic mem_err;
  } hz_ctrl_t;

  // Everything upstream of MEM holds while MEM/WB takes a bubble.
  function automatic hz_ctrl_t freeze_ctrl();
    hz_ctrl_t c;
    c               = '0;
    c.pc_stall      = 1'b1;
    c.if_id_stall   = 1'b1;
    c.id_ex_hold    = 1'b1;
    c.ex_mem_hold   = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX/MEM observations in,
// stall/hold/flush/bubble controls out.
interface hazard_ctrl_if;
  import vertex_pkg::*;

  logic             id_valid_i;
  logic [REG_W-1:0] id_rs1_i;
  logic [REG_W-1:0] id_rs2_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             ex_mem_read_i;
  logic             ex_redirect_i;
  logic             mem_req_i;
  logic             mem_ready_i;

  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_bubble_o;
  logic             id_ex_hold_o;
  logic             ex_mem_hold_o;
  logic             mem_wb_bubble_o;
  logic             mem_err_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_rd_i, ex_mem_read_i, ex_redirect_i, mem_req_i, mem_ready_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
           id_ex_hold_o, ex_mem_hold_o, mem_wb_bubble_o, mem_err_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_rd_i, ex_mem_read_i, ex_redirect_i, mem_req_i, mem_ready_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
           id_ex_hold_o, ex_mem_hold_o, mem_wb_bubble_o, mem_err_o
  );

endinterface

// File: rtl/hazard_ctrl_load_use.sv
// Load-use detector: flags an ID instruction that reads the register a load
// in EX is about to write. Purely combinational.
module load_use_detect
  import vertex_pkg::*;
(
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  output logic             hit_o
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hard-wired, so a load into it never creates a dependency.
  assign hit_o = id_valid_i && ex_mem_read_i && (ex_rd_i != REG_X0)
                 && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, redirect flushes and
// data-memory waits with timeout. Define HAZARD_CTRL_PERF_EN for stall/flush counters.
module hazard_ctrl
  import vertex_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  hazard_ctrl_if.slave hif
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_e        state;
  logic [CNT_W-1:0] wait_cnt;
  logic             load_use;
  logic             mem_stall;
  hz_ctrl_t         ctl;

  load_use_detect u_lud (
    .id_valid_i    (hif.id_valid_i),
    .id_rs1_i      (hif.id_rs1_i),
    .id_rs2_i      (hif.id_rs2_i),
    .id_uses_rs1_i (hif.id_uses_rs1_i),
    .id_uses_rs2_i (hif.id_uses_rs2_i),
    .ex_rd_i       (hif.ex_rd_i),
    .ex_mem_read_i (hif.ex_mem_read_i),
    .hit_o         (load_use)
  );

  assign mem_stall = hif.mem_req_i && !hif.mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            wait_cnt <= CNT_ONE;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A ready arriving on the timeout cycle still completes normally.
          if (hif.mem_ready_i) begin
            wait_cnt <= '0;
            state    <= RUN;
          end else if (wait_cnt == CNT_LAST) begin
            state    <= ABORT;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        ABORT: begin
          wait_cnt <= '0;
          state    <= RUN;
        end
        default: begin
          wait_cnt <= '0;
          state    <= RUN;
        end
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    if (!rst_i) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            ctl = freeze_ctrl();
          end else if (hif.ex_redirect_i) begin
            ctl.if_id_flush  = 1'b1;
            ctl.id_ex_bubble = 1'b1;
          end else if (load_use) begin
            ctl.pc_stall     = 1'b1;
            ctl.if_id_stall  = 1'b1;
            ctl.id_ex_bubble = 1'b1;
          end
        end
        // Redirects and load-use stay pending in the frozen stages until release.
        WAIT: begin
          if (!hif.mem_ready_i) ctl = freeze_ctrl();
        end
        ABORT: begin
          ctl.mem_err       = 1'b1;
          ctl.mem_wb_bubble = 1'b1;
        end
        default: ctl = '0;
      endcase
    end
  end

  assign hif.pc_stall_o      = ctl.pc_stall;
  assign hif.if_id_stall_o   = ctl.if_id_stall;
  assign hif.if_id_flush_o   = ctl.if_id_flush;
  assign hif.id_ex_bubble_o  = ctl.id_ex_bubble;
  assign hif.id_ex_hold_o    = ctl.id_ex_hold;
  assign hif.ex_mem_hold_o   = ctl.ex_mem_hold;
  assign hif.mem_wb_bubble_o = ctl.mem_wb_bubble;
  assign hif.mem_err_o       = ctl.mem_err;

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (ctl.pc_stall && !ctl.if_id_flush) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (ctl.if_id_flush)                  flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (MEM_TIMEOUT=4): vector table for single-cycle RUN
// decisions plus hand-built multi-cycle wait/timeout/reset sequences.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .hif   (hif)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] exp;
    string      name;
  } vec_t;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_err}
  localparam logic [7:0] ZERO = 8'b0000_0000;
  localparam logic [7:0] FRZ  = 8'b1100_1110;
  localparam logic [7:0] LU   = 8'b1101_0000;
  localparam logic [7:0] RED  = 8'b0011_0000;
  localparam logic [7:0] ABT  = 8'b0000_0011;

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  vec_t vecs[9];

  wire [7:0] act = {hif.pc_stall_o, hif.if_id_stall_o, hif.if_id_flush_o, hif.id_ex_bubble_o,
                    hif.id_ex_hold_o, hif.ex_mem_hold_o, hif.mem_wb_bubble_o, hif.mem_err_o};

  function automatic stim_t st(logic rst, logic iv, logic [4:0] rs1, logic [4:0] rs2,
                               logic u1, logic u2, logic [4:0] rd, logic mr,
                               logic redir, logic mreq, logic mrdy);
    stim_t s;
    s.rst = rst; s.iv = iv; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    s.rd = rd; s.mr = mr; s.redir = redir; s.mreq = mreq; s.mrdy = mrdy;
    return s;
  endfunction

  // Drive one cycle, queue its expectation, compare mid-cycle, advance.
  task automatic step(input stim_t s, input logic [7:0] e, input string name);
    logic [7:0] want;
    rst_i             = s.rst;
    hif.id_valid_i    = s.iv;
    hif.id_rs1_i      = s.rs1;
    hif.id_rs2_i      = s.rs2;
    hif.id_uses_rs1_i = s.u1;
    hif.id_uses_rs2_i = s.u2;
    hif.ex_rd_i       = s.rd;
    hif.ex_mem_read_i = s.mr;
    hif.ex_redirect_i = s.redir;
    hif.mem_req_i     = s.mreq;
    hif.mem_ready_i   = s.mrdy;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, want);
    end
    @(posedge clk);
    #1;
  endtask

  stim_t idle, memw, memr, ldu;

  initial begin
    idle = st(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    memw = st(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    memr = st(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    ldu  = st(0, 1, 5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0);

    vecs[0] = '{st(0, 1, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0), LU,   "lu_rs2"};
    vecs[1] = '{idle,                                          ZERO, "lu_release"};
    vecs[2] = '{st(0, 1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0), ZERO, "load_x0"};
    vecs[3] = '{st(0, 1, 5'd5, 5'd2, 1, 1, 5'd5, 1, 1, 0, 0), RED,  "redir_over_lu"};
    vecs[4] = '{st(0, 1, 5'd7, 5'd1, 0, 1, 5'd7, 1, 0, 0, 0), ZERO, "rs1_unused"};
    vecs[5] = '{st(0, 1, 5'd9, 5'd1, 1, 0, 5'd9, 0, 0, 0, 0), ZERO, "not_load"};
    vecs[6] = '{st(0, 0, 5'd9, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0), ZERO, "id_invalid"};
    vecs[7] = '{st(0, 1, 5'd31, 5'd1, 1, 1, 5'd31, 1, 0, 0, 0), LU, "lu_rs1_x31"};
    vecs[8] = '{st(0, 1, 5'd4, 5'd4, 1, 1, 5'd4, 1, 0, 1, 1), LU,   "mem_ready_lu"};

    rst_i = 1'b1;
    @(posedge clk);
    #1;
    step(st(1, 1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0), ZERO, "reset_outputs");

    for (int i = 0; i < 9; i++) step(vecs[i].s, vecs[i].exp, vecs[i].name);

    // Three unready cycles then release; redirect held during the wait is deferred.
    step(memw, FRZ, "wait_c1");
    step(st(0, 1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0), FRZ, "wait_c2_redir");
    step(st(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0), FRZ, "wait_c3_redir");
    step(st(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1), ZERO, "wait_release");
    step(st(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0), RED, "redir_after_wait");
    step(ldu, LU, "run_after_wait");

    // Timeout: error pulse exactly 4 cycles after the first unready cycle.
    for (int c = 1; c <= 4; c++) step(memw, FRZ, $sformatf("to_freeze_c%0d", c));
    step(memw, ABT, "to_abort_c5");
    step(idle, ZERO, "to_no_repeat_err");
    step(ldu, LU, "to_back_run");

    // Ready on the cycle the counter would hit the limit: no error.
    for (int c = 1; c <= 3; c++) step(memw, FRZ, $sformatf("late_freeze_c%0d", c));
    step(memr, ZERO, "late_ready_c4");
    step(idle, ZERO, "late_no_err");

    // Reset in the middle of a wait, then a full timeout proves the counter restarted.
    step(memw, FRZ, "rst_wait_c1");
    step(memw, FRZ, "rst_wait_c2");
    step(st(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0), ZERO, "rst_mid_wait");
    step(ldu, LU, "rst_back_run");
    for (int c = 1; c <= 4; c++) step(memw, FRZ, $sformatf("rst_to_c%0d", c));
    step(memw, ABT, "rst_to_abort");
    step(idle, ZERO, "rst_to_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
